alu_pipe_cc: RTL and testbench
==============================

# alu_pipe_cc

Registered, parametrised execute-stage ALU for the Y86-64 datapath. It has a valid/ready handshake on input and output and an architectural condition-code register (ZF/SF/OF). Operand width is parametrised, and the op set grows from 2-bit add/sub/and/xor to a 3-bit function field. It sits between decode (operand supply) and memory/write-back, and replaces the purely combinational ALU.

## Interface
- `WIDTH`, 64: operand/result width in bits; ≥ 8, power of two.
- `SHW`, $clog2(WIDTH): shift-amount width (derived, not overridden).
- `clk`: in, 1, rising-edge clock.
- `rst`: in, 1, reset, synchronous, active-high.
- `in_valid`: in, 1, operation offered.
- `in_ready`: out, 1, block can accept this cycle.
- `in_fn`: in, 3, function code (see Operation).
- `in_a`: in, WIDTH, operand A (signed two's complement).
- `in_b`: in, WIDTH, operand B (signed two's complement).
- `in_set_cc`: in, 1, update CC with this op's flags.
- `out_valid`: out, 1, result register holds an undelivered result.
- `out_ready`: in, 1, downstream accepts result.
- `out_result`: out, WIDTH, registered result.
- `out_of`: out, 1, registered signed-overflow flag of this result.
- `cc_zf`, `cc_sf`, `cc_of`: out, 1 each, condition-code register.

## Operation
- Function codes: 000 ADD a+b; 001 SUB a−b; 010 AND; 011 XOR; 100 OR; 101 SHL a<<b[SHW-1:0]; 110 SHR (logical); 111 SAR (arithmetic).
- Arithmetic is modulo 2^WIDTH. Carry-out is discarded.
- ADD overflow: a and b have the same sign and the result sign differs.
- SUB overflow: a and b have different signs and the result sign differs from a. Overflow is 0 for all other ops.
- Shift amount uses only the low SHW bits of b. Upper bits are ignored; 65 with WIDTH=64 shifts by 1.
- An accept happens when `in_valid && in_ready`.
- On accept, the result and overflow load into the output register and `out_valid` is set.
- On accept with `in_set_cc=1`: ZF ← (result==0), SF ← result[WIDTH-1], OF ← overflow, loaded on the same edge.
- On accept with `in_set_cc=0`, CC holds.
- `in_ready = !out_valid || out_ready`, a combinational path from `out_ready`.
- `out_valid` clears on a cycle with `out_ready && out_valid` and no accept.
- Deliver and accept in the same cycle: the output register is overwritten with the new result and `out_valid` stays 1.
- While `out_valid && !out_ready`: `out_result`, `out_of` and CC are frozen, and input is not accepted.
- `in_fn`/operands while `in_valid=0` are don't-care and have no effect.
- Reset values: `out_valid`=0, `out_result`=0, `out_of`=0, `cc_zf`=1, `cc_sf`=0, `cc_of`=0.
- Reset mid-operation: a pending undelivered result is discarded. `rst` has priority over an accept in the same cycle.

## Timing
- Latency 1 cycle: an op accepted at edge N appears on `out_result`/`out_valid` after edge N.
- CC updates on the same edge N, so CC after edge N reflects the most recent set_cc op.
- Throughput 1 op/cycle with `out_ready` held high.
- No combinational path from `in_*` to `out_*`. The only combinational path is `out_ready` → `in_ready`.
- All state updates on rising `clk`. No asynchronous behaviour.

## Structure
- Shared package `alu_pkg` holds:
  - `localparam` function codes `FN_ADD`…`FN_SAR` (3-bit);
  - packed struct `cc_t` {zf, sf, of};
  - the CC reset constant `CC_RESET` = {1,0,0}.
- Sub-module `alu_core #(WIDTH)`: purely combinational fn/a/b → result/overflow.
- Top-level `alu_pipe_cc` holds the output register, the handshake and the CC register.

## Test plan
- ADD, WIDTH=64, a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_cc=1 → next cycle result 0x8000_0000_0000_0000, out_of=1, cc ZF=0 SF=1 OF=1.
- SUB a=5, b=5, set_cc=1, then XOR a=3, b=1, set_cc=0 → results 0 then 2; CC stays ZF=1 SF=0 OF=0 after both.
- SAR a=0x8000_0000_0000_0000, b=0x41 → result 0xC000_0000_0000_0000, out_of=0.
- Backpressure: out_ready=0, issue ADD 1+2 then AND 6&3 → first accepted, in_ready=0, out_result=3 held. Raise out_ready → 3 delivered, 2 accepted the same cycle, then 2 delivered.
- Streaming with out_ready=1: ten back-to-back ops → ten results on consecutive cycles, in_ready constantly 1.
- Reset with out_valid=1 and in_valid=1 → after the edge out_valid=0, out_result=0, CC ZF=1 SF=0 OF=0, input op dropped.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared function codes and condition-code types for the execute-stage ALU
package alu_pkg;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_XOR = 3'b011;
  localparam logic [2:0] FN_OR  = 3'b100;
  localparam logic [2:0] FN_SHL = 3'b101;
  localparam logic [2:0] FN_SHR = 3'b110;
  localparam logic [2:0] FN_SAR = 3'b111;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath producing result and signed overflow
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [2:0]       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;

  assign sum   = a + b;
  assign diff  = a - b;
  // Only the low SHW bits of b select the shift distance; upper bits are ignored.
  assign shamt = b[SHW-1:0];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (fn)
      FN_ADD: begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      FN_SUB: begin
        result   = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      FN_AND:  result = a & b;
      FN_XOR:  result = a ^ b;
      FN_OR:   result = a | b;
      FN_SHL:  result = a << shamt;
      FN_SHR:  result = a >> shamt;
      FN_SAR:  result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe_cc.sv
// rtl/alu_pipe_cc.sv - registered execute-stage ALU with valid/ready handshake and CC register
module alu_pipe_cc
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_of,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  logic [WIDTH-1:0] core_result;
  logic             core_overflow;
  logic             accept;
  cc_t              cc_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .fn       (in_fn),
    .a        (in_a),
    .b        (in_b),
    .result   (core_result),
    .overflow (core_overflow)
  );

  // A full output register can still take a new op when it is being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_of     <= 1'b0;
      cc_q       <= CC_RESET;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= core_result;
      out_of     <= core_overflow;
      if (in_set_cc) begin
        cc_q.zf <= (core_result == '0);
        cc_q.sf <= core_result[WIDTH-1];
        cc_q.of <= core_overflow;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign cc_zf = cc_q.zf;
  assign cc_sf = cc_q.sf;
  assign cc_of = cc_q.of;

endmodule

// File: tb/tb_alu_pipe_cc.sv
// tb/tb_alu_pipe_cc.sv - directed self-checking bench for alu_pipe_cc
module tb_alu_pipe_cc;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_fn;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_set_cc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_of;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;

  int passed = 0;
  int total  = 0;

  alu_pipe_cc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fn      (in_fn),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_set_cc  (in_set_cc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_of     (out_of),
    .cc_zf      (cc_zf),
    .cc_sf      (cc_sf),
    .cc_of      (cc_of)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] fn, input logic [W-1:0] a, input logic [W-1:0] b, input logic set_cc);
    in_valid  = 1'b1;
    in_fn     = fn;
    in_a      = a;
    in_b      = b;
    in_set_cc = set_cc;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_fn     = 3'b000;
    in_a      = '0;
    in_b      = '0;
    in_set_cc = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    out_ready = 1'b1;
    do_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else passed++;
    total++; if (out_result !== 64'h0) $display("FAIL reset_result got %h exp 0", out_result); else passed++;
    total++; if (out_of !== 1'b0) $display("FAIL reset_of got %b exp 0", out_of); else passed++;
    total++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) $display("FAIL reset_cc got %b exp 100", {cc_zf, cc_sf, cc_of}); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1;
    drive(3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    tick();
    idle();
    total++; if (out_valid !== 1'b1) $display("FAIL add_valid got %b exp 1", out_valid); else passed++;
    total++; if (out_result !== 64'h8000_0000_0000_0000) $display("FAIL add_result got %h exp 8000000000000000", out_result); else passed++;
    total++; if (out_of !== 1'b1) $display("FAIL add_of got %b exp 1", out_of); else passed++;
    total++; if ({cc_zf, cc_sf, cc_of} !== 3'b011) $display("FAIL add_cc got %b exp 011", {cc_zf, cc_sf, cc_of}); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL add_drain got %b exp 0", out_valid); else passed++;
    total++; if (out_result !== 64'h8000_0000_0000_0000) $display("FAIL add_hold_idle got %h exp 8000000000000000", out_result); else passed++;
  endtask

  task automatic test_sub_xor_cc();
    out_ready = 1'b1;
    drive(3'b001, 64'd5, 64'd5, 1'b1);
    tick();
    total++; if (out_result !== 64'h0) $display("FAIL sub_result got %h exp 0", out_result); else passed++;
    total++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) $display("FAIL sub_cc got %b exp 100", {cc_zf, cc_sf, cc_of}); else passed++;
    drive(3'b011, 64'd3, 64'd1, 1'b0);
    tick();
    idle();
    total++; if (out_result !== 64'h2) $display("FAIL xor_result got %h exp 2", out_result); else passed++;
    total++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) $display("FAIL xor_cc_hold got %b exp 100", {cc_zf, cc_sf, cc_of}); else passed++;
  endtask

  task automatic test_ops();
    out_ready = 1'b1;
    drive(3'b111, 64'h8000_0000_0000_0000, 64'h41, 1'b0);
    tick();
    total++; if (out_result !== 64'hC000_0000_0000_0000) $display("FAIL sar_result got %h exp c000000000000000", out_result); else passed++;
    total++; if (out_of !== 1'b0) $display("FAIL sar_of got %b exp 0", out_of); else passed++;
    drive(3'b110, 64'h8000_0000_0000_0000, 64'h4, 1'b0);
    tick();
    total++; if (out_result !== 64'h0800_0000_0000_0000) $display("FAIL shr_result got %h exp 0800000000000000", out_result); else passed++;
    drive(3'b101, 64'h1, 64'd65, 1'b0);
    tick();
    total++; if (out_result !== 64'h2) $display("FAIL shl_wrap got %h exp 2", out_result); else passed++;
    drive(3'b100, 64'hF0, 64'h0F, 1'b0);
    tick();
    total++; if (out_result !== 64'hFF) $display("FAIL or_result got %h exp ff", out_result); else passed++;
    drive(3'b001, 64'h8000_0000_0000_0000, 64'h1, 1'b1);
    tick();
    total++; if (out_result !== 64'h7FFF_FFFF_FFFF_FFFF) $display("FAIL sub_ovf_result got %h exp 7fffffffffffffff", out_result); else passed++;
    total++; if (out_of !== 1'b1) $display("FAIL sub_ovf_of got %b exp 1", out_of); else passed++;
    total++; if ({cc_zf, cc_sf, cc_of} !== 3'b001) $display("FAIL sub_ovf_cc got %b exp 001", {cc_zf, cc_sf, cc_of}); else passed++;
    drive(3'b000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    tick();
    total++; if (out_result !== 64'h0 || out_of !== 1'b1) $display("FAIL add_neg_ovf got %h/%b exp 0/1", out_result, out_of); else passed++;
    total++; if ({cc_zf, cc_sf, cc_of} !== 3'b101) $display("FAIL add_neg_ovf_cc got %b exp 101", {cc_zf, cc_sf, cc_of}); else passed++;
    drive(3'b010, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    tick();
    idle();
    total++; if (out_result !== 64'h0F0F_0000_0F0F_0000 || out_of !== 1'b0) $display("FAIL and_result got %h/%b exp 0f0f00000f0f0000/0", out_result, out_of); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    idle();
    out_ready = 1'b1;
    do_reset();
    out_ready = 1'b0;
    drive(3'b000, 64'd1, 64'd2, 1'b0);
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 64'd3) $display("FAIL bp_first got %b/%h exp 1/3", out_valid, out_result); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", in_ready); else passed++;
    drive(3'b010, 64'd6, 64'd3, 1'b1);
    tick();
    total++; if (out_result !== 64'd3 || out_valid !== 1'b1) $display("FAIL bp_hold got %b/%h exp 1/3", out_valid, out_result); else passed++;
    total++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) $display("FAIL bp_cc_frozen got %b exp 100", {cc_zf, cc_sf, cc_of}); else passed++;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_comb got %b exp 1", in_ready); else passed++;
    tick();
    idle();
    total++; if (out_valid !== 1'b1 || out_result !== 64'd2) $display("FAIL bp_second got %b/%h exp 1/2", out_valid, out_result); else passed++;
    total++; if ({cc_zf, cc_sf, cc_of} !== 3'b000) $display("FAIL bp_cc_update got %b exp 000", {cc_zf, cc_sf, cc_of}); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_val;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(3'b000, W'(i), W'(i * 7), 1'b0);
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, in_ready); else passed++;
      tick();
      exp_val = W'(i * 8);
      total++; if (out_valid !== 1'b1 || out_result !== exp_val) $display("FAIL b2b_result[%0d] got %b/%h exp 1/%h", i, out_valid, out_result, exp_val); else passed++;
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(3'b001, 64'd0, 64'd1, 1'b1);
    tick();
    total++; if (out_valid !== 1'b1 || {cc_zf, cc_sf, cc_of} !== 3'b010) $display("FAIL rm_setup got %b/%b exp 1/010", out_valid, {cc_zf, cc_sf, cc_of}); else passed++;
    out_ready = 1'b1;
    drive(3'b000, 64'd9, 64'd9, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    total++; if (out_valid !== 1'b0 || out_result !== 64'h0 || out_of !== 1'b0) $display("FAIL rm_out got %b/%h/%b exp 0/0/0", out_valid, out_result, out_of); else passed++;
    total++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) $display("FAIL rm_cc got %b exp 100", {cc_zf, cc_sf, cc_of}); else passed++;
    tick();
    total++; if (out_valid !== 1'b0 || out_result !== 64'h0) $display("FAIL rm_dropped got %b/%h exp 0/0", out_valid, out_result); else passed++;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    test_reset();
    test_add_overflow();
    test_sub_xor_cc();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
